// File: rtl/kanagawa_pipelined_call_issuer_if.sv
// Call/beat/counter handshake bundle between the call issuer and its neighbours.
// master: environment side (calls in, beats out); slave: the issuer itself.
interface kanagawa_pipelined_call_issuer_if #(
  parameter int unsigned TCW  = 8,
  parameter int unsigned TAGW = 4
);
  logic            call_valid_in;
  logic            call_ready_out;
  logic [TCW-1:0]  call_max_thread_id_in;
  logic [TAGW-1:0] call_tag_in;
  logic            thread_valid_out;
  logic            thread_ready_in;
  logic [TCW-1:0]  thread_id_out;
  logic            thread_last_out;
  logic [TAGW-1:0] thread_tag_out;
  logic            counter_incr_out;
  logic [TCW-1:0]  counter_max_id_out;
  logic            counter_only_one_out;

  modport master (
    output call_valid_in, call_max_thread_id_in, call_tag_in, thread_ready_in,
    input  call_ready_out, thread_valid_out, thread_id_out, thread_last_out,
    input  thread_tag_out, counter_incr_out, counter_max_id_out, counter_only_one_out
  );

  modport slave (
    input  call_valid_in, call_max_thread_id_in, call_tag_in, thread_ready_in,
    output call_ready_out, thread_valid_out, thread_id_out, thread_last_out,
    output thread_tag_out, counter_incr_out, counter_max_id_out, counter_only_one_out
  );
endinterface

// File: rtl/kanagawa_pipelined_call_issuer.sv
// Expands pipelined function calls into per-thread beats and drives the thread counter.
// Optional KANAGAWA_CALL_ISSUER_STATS_EN adds saturating call/beat statistics ports.
module kanagawa_pipelined_call_issuer #(
  parameter int unsigned THREAD_COUNT_WIDTH = 8,
  parameter int unsigned TAG_WIDTH          = 4
) (
  input  logic clk,
  input  logic rst,
  kanagawa_pipelined_call_issuer_if.slave bus
`ifdef KANAGAWA_CALL_ISSUER_STATS_EN
  ,
  output logic [31:0] stat_calls_out,
  output logic [31:0] stat_threads_out
`endif
);

  localparam int unsigned TCW  = THREAD_COUNT_WIDTH;
  localparam int unsigned TAGW = TAG_WIDTH;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [TCW-1:0]  id_q, id_d;
  logic [TCW-1:0]  max_q, max_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic            ready_c;
  logic            incr_c;
  logic            last_c;
  logic            accept_c;

  // State and active-call registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      max_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      max_q   <= max_d;
      tag_q   <= tag_d;
    end
  end

  // Next state; last beat found by compare so id never wraps past max
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    max_d    = max_q;
    tag_d    = tag_q;
    ready_c  = 1'b0;
    incr_c   = 1'b0;
    last_c   = 1'b0;
    accept_c = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
      end
      ISSUE: begin
        last_c  = (id_q == max_q);
        incr_c  = bus.thread_ready_in;
        ready_c = last_c & bus.thread_ready_in;
        if (incr_c) begin
          if (!last_c) id_d = id_q + TCW'(1);
          else         state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    accept_c = bus.call_valid_in & ready_c;
    if (accept_c) begin
      state_d = ISSUE;
      id_d    = '0;
      max_d   = bus.call_max_thread_id_in;
      tag_d   = bus.call_tag_in;
    end
  end

  assign bus.call_ready_out       = ready_c;
  assign bus.thread_valid_out     = (state_q == ISSUE);
  assign bus.thread_id_out        = id_q;
  assign bus.thread_last_out      = last_c;
  assign bus.thread_tag_out       = tag_q;
  assign bus.counter_incr_out     = incr_c;
  assign bus.counter_max_id_out   = max_q;
  assign bus.counter_only_one_out = (state_q == ISSUE) && (max_q == '0);

`ifdef KANAGAWA_CALL_ISSUER_STATS_EN
  logic [31:0] calls_q;
  logic [31:0] threads_q;

  // Saturating statistics counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      calls_q   <= '0;
      threads_q <= '0;
    end else begin
      if (accept_c && (calls_q != 32'hFFFF_FFFF))  calls_q   <= calls_q + 32'd1;
      if (incr_c && (threads_q != 32'hFFFF_FFFF))  threads_q <= threads_q + 32'd1;
    end
  end

  assign stat_calls_out   = calls_q;
  assign stat_threads_out = threads_q;
`endif

endmodule

// File: tb/tb_kanagawa_pipelined_call_issuer.sv
// Directed bench for the pipelined call issuer: 8-bit-id instance plus a 4-bit full-width instance.
module tb_kanagawa_pipelined_call_issuer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  kanagawa_pipelined_call_issuer_if #(.TCW(8), .TAGW(4)) a ();
  kanagawa_pipelined_call_issuer_if #(.TCW(4), .TAGW(4)) b ();

`ifdef KANAGAWA_CALL_ISSUER_STATS_EN
  logic [31:0] a_calls, a_threads, b_calls, b_threads;
`endif

  kanagawa_pipelined_call_issuer #(.THREAD_COUNT_WIDTH(8), .TAG_WIDTH(4)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (a)
`ifdef KANAGAWA_CALL_ISSUER_STATS_EN
    ,
    .stat_calls_out   (a_calls),
    .stat_threads_out (a_threads)
`endif
  );

  kanagawa_pipelined_call_issuer #(.THREAD_COUNT_WIDTH(4), .TAG_WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b)
`ifdef KANAGAWA_CALL_ISSUER_STATS_EN
    ,
    .stat_calls_out   (b_calls),
    .stat_threads_out (b_threads)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1-2 time units after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic beat(input string nm, input int id, input int last, input int tag,
                      input int incr, input int oo);
    chk({nm, ".valid"}, 64'(a.thread_valid_out), 64'(1));
    chk({nm, ".id"},    64'(a.thread_id_out), 64'(id));
    chk({nm, ".last"},  64'(a.thread_last_out), 64'(last));
    chk({nm, ".tag"},   64'(a.thread_tag_out), 64'(tag));
    chk({nm, ".incr"},  64'(a.counter_incr_out), 64'(incr));
    chk({nm, ".one"},   64'(a.counter_only_one_out), 64'(oo));
  endtask

  task automatic idle_a(input string nm);
    chk({nm, ".valid"}, 64'(a.thread_valid_out), 64'(0));
    chk({nm, ".ready"}, 64'(a.call_ready_out), 64'(1));
  endtask

  task automatic call_a(input int mx, input int tag);
    a.call_valid_in         = 1'b1;
    a.call_max_thread_id_in = 8'(mx);
    a.call_tag_in           = 4'(tag);
  endtask

  initial begin
    a.call_valid_in = 1'b0; a.call_max_thread_id_in = '0; a.call_tag_in = '0;
    a.thread_ready_in = 1'b1;
    b.call_valid_in = 1'b0; b.call_max_thread_id_in = '0; b.call_tag_in = '0;
    b.thread_ready_in = 1'b1;

    // Reset values
    repeat (3) cyc();
    settle();
    chk("rst.ready",  64'(a.call_ready_out), 64'(1));
    chk("rst.valid",  64'(a.thread_valid_out), 64'(0));
    chk("rst.last",   64'(a.thread_last_out), 64'(0));
    chk("rst.id",     64'(a.thread_id_out), 64'(0));
    chk("rst.tag",    64'(a.thread_tag_out), 64'(0));
    chk("rst.maxid",  64'(a.counter_max_id_out), 64'(0));
    chk("rst.one",    64'(a.counter_only_one_out), 64'(0));
    chk("rst.incr",   64'(a.counter_incr_out), 64'(0));
    rst = 1'b0;
    cyc();

    // Call max 3 tag 5, ready high: ids 0..3 on consecutive cycles
    call_a(3, 5);
    settle();
    chk("t1.accept_ready", 64'(a.call_ready_out), 64'(1));
    cyc();
    a.call_valid_in = 1'b0;
    settle();
    beat("t1.b0", 0, 0, 5, 1, 0);
    chk("t1.maxid", 64'(a.counter_max_id_out), 64'(3));
    chk("t1.ready_mid", 64'(a.call_ready_out), 64'(0));
    cyc(); settle(); beat("t1.b1", 1, 0, 5, 1, 0);
    cyc(); settle(); beat("t1.b2", 2, 0, 5, 1, 0);
    cyc(); settle(); beat("t1.b3", 3, 1, 5, 1, 0);
    chk("t1.ready_last", 64'(a.call_ready_out), 64'(1));
    cyc(); settle(); idle_a("t1.end");

    // Single-thread call
    call_a(0, 9);
    cyc();
    a.call_valid_in = 1'b0;
    settle();
    beat("t2.b0", 0, 1, 9, 1, 1);
    cyc(); settle(); idle_a("t2.end");

    // Backpressure on id 1
    call_a(2, 3);
    cyc();
    a.call_valid_in = 1'b0;
    settle(); beat("t3.b0", 0, 0, 3, 1, 0);
    cyc(); a.thread_ready_in = 1'b0;
    settle(); beat("t3.stall", 1, 0, 3, 0, 0);
    cyc(); a.thread_ready_in = 1'b1;
    settle(); beat("t3.b1", 1, 0, 3, 1, 0);
    cyc(); settle(); beat("t3.b2", 2, 1, 3, 1, 0);
    cyc(); settle(); idle_a("t3.end");

    // Back-to-back: A (max1 tag1), B (max2 tag2) pending during A
    call_a(1, 1);
    cyc();
    call_a(2, 2);
    settle(); beat("t4.a0", 0, 0, 1, 1, 0);
    chk("t4.a0_ready", 64'(a.call_ready_out), 64'(0));
    cyc(); settle(); beat("t4.a1", 1, 1, 1, 1, 0);
    chk("t4.a1_ready", 64'(a.call_ready_out), 64'(1));
    cyc();
    a.call_valid_in = 1'b0;
    settle(); beat("t4.b0", 0, 0, 2, 1, 0);
    chk("t4.b_maxid", 64'(a.counter_max_id_out), 64'(2));
    cyc(); settle(); beat("t4.b1", 1, 0, 2, 1, 0);
    cyc(); settle(); beat("t4.b2", 2, 1, 2, 1, 0);
    cyc(); settle(); idle_a("t4.end");

    // Full-width call on the 4-bit instance
    b.call_valid_in = 1'b1; b.call_max_thread_id_in = 4'd15; b.call_tag_in = 4'd7;
    cyc();
    b.call_valid_in = 1'b0;
    settle();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t5.valid%0d", i), 64'(b.thread_valid_out), 64'(1));
      chk($sformatf("t5.id%0d", i),    64'(b.thread_id_out), 64'(i));
      chk($sformatf("t5.last%0d", i),  64'(b.thread_last_out), 64'(i == 15));
      chk($sformatf("t5.tag%0d", i),   64'(b.thread_tag_out), 64'(7));
      cyc(); settle();
    end
    chk("t5.end_valid", 64'(b.thread_valid_out), 64'(0));
    chk("t5.end_ready", 64'(b.call_ready_out), 64'(1));
    cyc(); settle();
    chk("t5.no_wrap", 64'(b.thread_valid_out), 64'(0));

    // Reset asserted on id 2 of a max-5 call
    call_a(5, 4);
    cyc();
    a.call_valid_in = 1'b0;
    settle(); beat("t6.b0", 0, 0, 4, 1, 0);
    cyc(); settle(); beat("t6.b1", 1, 0, 4, 1, 0);
    cyc(); settle(); beat("t6.b2", 2, 0, 4, 1, 0);
    rst = 1'b1;
    settle();
    chk("t6.rst_valid", 64'(a.thread_valid_out), 64'(0));
    chk("t6.rst_id",    64'(a.thread_id_out), 64'(0));
    chk("t6.rst_ready", 64'(a.call_ready_out), 64'(1));
    cyc();
    rst = 1'b0;
    settle(); idle_a("t6.after_rst");
    cyc(); settle(); idle_a("t6.no_resume");
    call_a(1, 6);
    cyc();
    a.call_valid_in = 1'b0;
    settle(); beat("t6.n0", 0, 0, 6, 1, 0);
    cyc(); settle(); beat("t6.n1", 1, 1, 6, 1, 0);
    cyc(); settle(); idle_a("t6.end");
`ifdef KANAGAWA_CALL_ISSUER_STATS_EN
    chk("stat.calls",   64'(a_calls), 64'(1));
    chk("stat.threads", 64'(a_threads), 64'(2));
    chk("stat.b_calls", 64'(b_calls), 64'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
